genius_seq_engine: RTL and testbench

//   Parametrised Genius/Simon game engine. Stores a growing random colour sequence,

---
 rtl/genius_seq_engine_if.sv | 32 +++
 rtl/genius_seq_engine.sv | 164 ++++++++++++++++
 tb/tb_genius_seq_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/genius_seq_engine_if.sv
// Player/display bundle of the Genius game engine.
// The button decoder and renderer side is the master; the engine is the slave.
interface genius_seq_engine_if #(
  parameter int MAX_LEN = 16,
  parameter int COLOR_W = 2,
  parameter int LIVES   = 1
);
  localparam int LEVEL_W = $clog2(MAX_LEN + 1);
  localparam int LIVES_W = $clog2(LIVES + 1);

  logic               start;
  logic [COLOR_W-1:0] rnd;
  logic               btn_valid;
  logic [COLOR_W-1:0] btn_color;
  logic               disp_on;
  logic [COLOR_W-1:0] disp_color;
  logic               win;
  logic               lose;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives_left;
  logic [3:0]         state;

  modport master (
    output start, rnd, btn_valid, btn_color,
    input  disp_on, disp_color, win, lose, level, lives_left, state
  );

  modport slave (
    input  start, rnd, btn_valid, btn_color,
    output disp_on, disp_color, win, lose, level, lives_left, state
  );
endinterface

// File: rtl/genius_seq_engine.sv
// Genius/Simon game engine: grows a random colour sequence, replays it and
// checks the player's echo, with internal display/input timers and lives.
module genius_seq_engine #(
  parameter int MAX_LEN        = 16,
  parameter int COLOR_W        = 2,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 5_000_000,
  parameter int TIMEOUT_CYCLES = 150_000_000,
  parameter int LIVES          = 1
) (
  input logic                clk,
  input logic                rst_n,
  genius_seq_engine_if.slave bus
);

  localparam int LEVEL_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int T_MAX0  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int T_MAX   = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADD      = 4'd1,
    SHOW_ON  = 4'd2,
    SHOW_GAP = 4'd3,
    WAIT_IN  = 4'd4,
    ECHO     = 4'd5,
    LEVEL_UP = 4'd6,
    MISS     = 4'd7,
    WIN      = 4'd8,
    LOSE     = 4'd9
  } state_t;

  state_t             state, state_next;
  logic [LEVEL_W-1:0] level, level_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [LIVES_W-1:0] lives_left, lives_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [COLOR_W-1:0] echo_color, echo_next;
  logic               seq_we;
  logic               at_last;
  logic [COLOR_W-1:0] seq [MAX_LEN];

  assign at_last = (LEVEL_W'(idx) == level - LEVEL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      level      <= '0;
      idx        <= '0;
      lives_left <= LIVES_W'(LIVES);
      timer      <= '0;
      echo_color <= '0;
    end else begin
      state      <= state_next;
      level      <= level_next;
      idx        <= idx_next;
      lives_left <= lives_next;
      timer      <= timer_next;
      echo_color <= echo_next;
    end
  end

  // Sequence storage is never cleared; only entries below level are read.
  always_ff @(posedge clk) begin
    if (seq_we) seq[level[IDX_W-1:0]] <= bus.rnd;
  end

  always_comb begin
    state_next = state;
    level_next = level;
    idx_next   = idx;
    lives_next = lives_left;
    timer_next = timer;
    echo_next  = echo_color;
    seq_we     = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          state_next = ADD;
          level_next = '0;
          lives_next = LIVES_W'(LIVES);
        end
      end
      ADD: begin
        seq_we     = 1'b1;
        level_next = level + LEVEL_W'(1);
        idx_next   = '0;
        state_next = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer == SHOW_LAST) state_next = SHOW_GAP;
        else                    timer_next = timer + TIMER_W'(1);
      end
      SHOW_GAP: begin
        if (timer == GAP_LAST) begin
          if (at_last) begin
            idx_next   = '0;
            state_next = WAIT_IN;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = SHOW_ON;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      // A press on the final timeout cycle still counts as a press.
      WAIT_IN: begin
        if (bus.btn_valid) begin
          echo_next  = bus.btn_color;
          state_next = (bus.btn_color == seq[idx]) ? ECHO : MISS;
        end else if (timer == TO_LAST) begin
          state_next = MISS;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      ECHO: begin
        if (timer == SHOW_LAST) begin
          if (at_last) begin
            state_next = LEVEL_UP;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = WAIT_IN;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      LEVEL_UP: begin
        state_next = (level == LEVEL_W'(MAX_LEN)) ? WIN : ADD;
      end
      MISS: begin
        if (lives_left > LIVES_W'(1)) begin
          lives_next = lives_left - LIVES_W'(1);
          idx_next   = '0;
          state_next = SHOW_ON;
        end else begin
          lives_next = '0;
          state_next = LOSE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) timer_next = '0;
  end

  assign bus.disp_on    = (state == SHOW_ON) || (state == ECHO);
  assign bus.disp_color = (state == SHOW_ON) ? seq[idx] :
                          (state == ECHO)    ? echo_color : '0;
  assign bus.win        = (state == WIN);
  assign bus.lose       = (state == LOSE);
  assign bus.level      = level;
  assign bus.lives_left = lives_left;
  assign bus.state      = state;

endmodule

// File: tb/tb_genius_seq_engine.sv
// Directed self-checking bench for genius_seq_engine with small timing
// parameters (MAX_LEN=3, SHOW=3, GAP=2, TIMEOUT=10, LIVES=2).
module tb_genius_seq_engine;

  localparam int MAX_LEN = 3;
  localparam int COLOR_W = 2;
  localparam int SHOW    = 3;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 10;
  localparam int LIVES   = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;
  int   n;

  genius_seq_engine_if #(.MAX_LEN(MAX_LEN), .COLOR_W(COLOR_W), .LIVES(LIVES)) bus ();

  genius_seq_engine #(
    .MAX_LEN(MAX_LEN), .COLOR_W(COLOR_W), .SHOW_CYCLES(SHOW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .LIVES(LIVES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] r, input logic v, input logic [1:0] c);
    bus.start     = s;
    bus.rnd       = r;
    bus.btn_valid = v;
    bus.btn_color = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitState(input string tag, input logic [3:0] target, input int budget);
    int k;
    k = 0;
    while (bus.state !== target && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput(tag, 32'(bus.state), 32'(target));
  endtask

  task automatic measureState(input logic [3:0] st, output int cycles);
    cycles = 0;
    while (bus.state === st && cycles < 50) begin
      cycles++;
      tick(1);
    end
  endtask

  // Wait for the input window, press one colour and expect the echo state.
  task automatic pressColor(input string tag, input logic [1:0] c);
    logic [1:0] r;
    r = bus.rnd;
    waitState({tag, "_wait"}, 4'd4, 80);
    applyStimulus(1'b0, r, 1'b1, c);
    tick(1);
    applyStimulus(1'b0, r, 1'b0, 2'd0);
    checkOutput({tag, "_echo"}, 32'(bus.state), 32'd5);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0);
    tick(2);
    checkOutput("rst_state",  32'(bus.state), 32'd0);
    checkOutput("rst_disp",   32'(bus.disp_on), 32'd0);
    checkOutput("rst_color",  32'(bus.disp_color), 32'd0);
    checkOutput("rst_level",  32'(bus.level), 32'd0);
    checkOutput("rst_lives",  32'(bus.lives_left), 32'd2);
    checkOutput("rst_win",    32'(bus.win), 32'd0);
    checkOutput("rst_lose",   32'(bus.lose), 32'd0);
    rst_n = 1'b1;
    tick(1);

    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
    tick(1);
    checkOutput("start_add", 32'(bus.state), 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b0, 2'd0);
    tick(1);
    checkOutput("pre_rst_show",  32'(bus.state), 32'd2);
    checkOutput("pre_rst_disp",  32'(bus.disp_on), 32'd1);
    checkOutput("pre_rst_color", 32'(bus.disp_color), 32'd2);

    // Asynchronous reset in the middle of SHOW_ON.
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", 32'(bus.state), 32'd0);
    checkOutput("async_rst_disp",  32'(bus.disp_on), 32'd0);
    checkOutput("async_rst_color", 32'(bus.disp_color), 32'd0);
    checkOutput("async_rst_level", 32'(bus.level), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
    tick(1);
    checkOutput("restart_add",   32'(bus.state), 32'd1);
    checkOutput("restart_level", 32'(bus.level), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 2'd0);
    tick(1);
    checkOutput("show_state", 32'(bus.state), 32'd2);
    checkOutput("show_level", 32'(bus.level), 32'd1);
    checkOutput("show_color", 32'(bus.disp_color), 32'd2);
    measureState(4'd2, n);
    checkOutput("show_len", 32'(n), 32'(SHOW));
    checkOutput("gap_dark", 32'(bus.disp_on), 32'd0);
    measureState(4'd3, n);
    checkOutput("gap_len", 32'(n), 32'(GAP));
    checkOutput("wait_state", 32'(bus.state), 32'd4);
    checkOutput("wait_level", 32'(bus.level), 32'd1);

    applyStimulus(1'b0, 2'd1, 1'b0, 2'd0);
    pressColor("r1_p0", 2'd2);
    checkOutput("r1_echo_color", 32'(bus.disp_color), 32'd2);
    checkOutput("r1_echo_disp",  32'(bus.disp_on), 32'd1);
    applyStimulus(1'b0, 2'd1, 1'b1, 2'd0);
    tick(1);
    applyStimulus(1'b0, 2'd1, 1'b0, 2'd0);
    checkOutput("echo_ignores_btn", 32'(bus.state), 32'd5);
    waitState("r1_levelup", 4'd6, 10);
    tick(1);
    checkOutput("r1_add", 32'(bus.state), 32'd1);

    pressColor("r2_p0", 2'd2);
    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    pressColor("r2_p1", 2'd1);
    pressColor("r3_p0", 2'd2);
    pressColor("r3_p1", 2'd1);
    pressColor("r3_p2", 2'd3);
    waitState("win_state", 4'd8, 20);
    checkOutput("win_flag",  32'(bus.win), 32'd1);
    checkOutput("win_level", 32'(bus.level), 32'd3);
    checkOutput("win_lose",  32'(bus.lose), 32'd0);

    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0);
    tick(1);
    checkOutput("win_restart_add",   32'(bus.state), 32'd1);
    checkOutput("win_restart_level", 32'(bus.level), 32'd0);
    checkOutput("win_restart_flag",  32'(bus.win), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0);
    tick(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    pressColor("g2_r1", 2'd0);
    measureState(4'd5, n);
    checkOutput("echo_len", 32'(n), 32'(SHOW));
    pressColor("g2_r2p0", 2'd0);

    // Wrong colour at index 1 of a two-colour sequence.
    waitState("g2_wait1", 4'd4, 40);
    applyStimulus(1'b0, 2'd3, 1'b1, 2'd1);
    tick(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    checkOutput("miss_state", 32'(bus.state), 32'd7);
    tick(1);
    checkOutput("replay_state", 32'(bus.state), 32'd2);
    checkOutput("replay_lives", 32'(bus.lives_left), 32'd1);
    checkOutput("replay_level", 32'(bus.level), 32'd2);
    checkOutput("replay_first", 32'(bus.disp_color), 32'd0);
    waitState("replay_gap", 4'd3, 10);
    waitState("replay_on2", 4'd2, 10);
    checkOutput("replay_second", 32'(bus.disp_color), 32'd3);
    waitState("replay_done", 4'd4, 20);
    checkOutput("replay_done_level", 32'(bus.level), 32'd2);

    // Press on the very cycle the timeout would fire.
    tick(TIMEOUT - 1);
    checkOutput("still_waiting", 32'(bus.state), 32'd4);
    applyStimulus(1'b0, 2'd3, 1'b1, 2'd0);
    tick(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    checkOutput("press_on_timeout", 32'(bus.state), 32'd5);
    checkOutput("press_on_timeout_lives", 32'(bus.lives_left), 32'd1);

    waitState("to_wait", 4'd4, 10);
    measureState(4'd4, n);
    checkOutput("timeout_len", 32'(n), 32'(TIMEOUT));
    checkOutput("timeout_miss", 32'(bus.state), 32'd7);
    tick(1);
    checkOutput("lose_state", 32'(bus.state), 32'd9);
    checkOutput("lose_flag",  32'(bus.lose), 32'd1);
    checkOutput("lose_lives", 32'(bus.lives_left), 32'd0);
    checkOutput("lose_level", 32'(bus.level), 32'd2);
    applyStimulus(1'b0, 2'd3, 1'b1, 2'd3);
    tick(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    checkOutput("lose_ignores_btn", 32'(bus.state), 32'd9);

    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0);
    tick(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    checkOutput("lose_restart_add",   32'(bus.state), 32'd1);
    checkOutput("lose_restart_flag",  32'(bus.lose), 32'd0);
    checkOutput("lose_restart_lives", 32'(bus.lives_left), 32'd2);
    checkOutput("lose_restart_level", 32'(bus.level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
